// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder for game controls: move_left/move_right levels, rate-limited fire, pause toggle.
// Optional build macro WASD_KEYS_EN adds base A (1C) / D (23) as aliases for left / right.
module ps2_key_decoder #(
  parameter int FIRE_COOLDOWN  = 5_000_000,
  parameter int PREFIX_TIMEOUT = 50_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       pause,
  output logic [7:0] last_code,
  output logic [1:0] prefix_state
);

  localparam int COOL_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
  localparam int TO_W   = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] K_LEFT  = 8'h6B;
  localparam logic [7:0] K_RIGHT = 8'h74;
  localparam logic [7:0] K_SPACE = 8'h29;
  localparam logic [7:0] K_P     = 8'h4D;
  localparam logic [7:0] K_ESC   = 8'h76;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   to_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic              left_h, right_h, space_h, p_h;
  logic              last_dir;  // 0 = L, 1 = R

  logic ev_make, ev_break, ev_ext, is_ignored;
  logic mk_left, br_left, mk_right, br_right;
  logic mk_space, br_space, mk_p, br_p, mk_esc;
  logic mk_alias_l, mk_alias_r;
  logic left_h_n, right_h_n, alias_l_n, alias_r_n;
  logic left_any_n, right_any_n, last_dir_n, mapped_make;

`ifdef WASD_KEYS_EN
  logic a_h, d_h;
`endif

  assign prefix_state = state;

  always_comb begin
    is_ignored = ps2_key_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1};
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (ps2_key_pressed) begin
      case (state)
        S_IDLE:    ev_make = (ps2_key_data != B_EXT) && (ps2_key_data != B_BRK) && !is_ignored;
        S_EXT: begin
          ev_ext  = 1'b1;
          ev_make = (ps2_key_data != B_BRK);
        end
        S_BRK:     ev_break = 1'b1;
        S_EXT_BRK: begin
          ev_ext   = 1'b1;
          ev_break = 1'b1;
        end
        default: ;
      endcase
    end

    mk_left  = ev_make  &  ev_ext & (ps2_key_data == K_LEFT);
    br_left  = ev_break &  ev_ext & (ps2_key_data == K_LEFT);
    mk_right = ev_make  &  ev_ext & (ps2_key_data == K_RIGHT);
    br_right = ev_break &  ev_ext & (ps2_key_data == K_RIGHT);
    mk_space = ev_make  & ~ev_ext & (ps2_key_data == K_SPACE);
    br_space = ev_break & ~ev_ext & (ps2_key_data == K_SPACE);
    mk_p     = ev_make  & ~ev_ext & (ps2_key_data == K_P);
    br_p     = ev_break & ~ev_ext & (ps2_key_data == K_P);
    mk_esc   = ev_make  & ~ev_ext & (ps2_key_data == K_ESC);

    left_h_n  = mk_left  | (left_h  & ~br_left);
    right_h_n = mk_right | (right_h & ~br_right);

    mk_alias_l = 1'b0;
    mk_alias_r = 1'b0;
    alias_l_n  = 1'b0;
    alias_r_n  = 1'b0;
`ifdef WASD_KEYS_EN
    mk_alias_l = ev_make & ~ev_ext & (ps2_key_data == 8'h1C);
    mk_alias_r = ev_make & ~ev_ext & (ps2_key_data == 8'h23);
    alias_l_n  = mk_alias_l | (a_h & ~(ev_break & ~ev_ext & (ps2_key_data == 8'h1C)));
    alias_r_n  = mk_alias_r | (d_h & ~(ev_break & ~ev_ext & (ps2_key_data == 8'h23)));
`endif

    left_any_n  = left_h_n  | alias_l_n;
    right_any_n = right_h_n | alias_r_n;

    // Most recent directional make decides who wins while both are held.
    if (mk_left | mk_alias_l)
      last_dir_n = 1'b0;
    else if (mk_right | mk_alias_r)
      last_dir_n = 1'b1;
    else
      last_dir_n = last_dir;

    mapped_make = mk_left | mk_right | mk_space | mk_p | mk_esc | mk_alias_l | mk_alias_r;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      cool_cnt   <= '0;
      left_h     <= 1'b0;
      right_h    <= 1'b0;
      space_h    <= 1'b0;
      p_h        <= 1'b0;
      last_dir   <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      fire       <= 1'b0;
      pause      <= 1'b0;
      last_code  <= 8'h00;
    end else begin
      if (ps2_key_pressed) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (ps2_key_data == B_EXT)      state <= S_EXT;
            else if (ps2_key_data == B_BRK) state <= S_BRK;
          end
          S_EXT:   state <= (ps2_key_data == B_BRK) ? S_EXT_BRK : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        // A prefix that never gets its follow-up byte is dropped silently.
        if (to_cnt == TO_W'(PREFIX_TIMEOUT - 1)) begin
          state  <= S_IDLE;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      left_h   <= left_h_n;
      right_h  <= right_h_n;
      space_h  <= mk_space | (space_h & ~br_space);
      p_h      <= mk_p | (p_h & ~br_p);
      last_dir <= last_dir_n;

      move_left  <= left_any_n  & (~right_any_n | ~last_dir_n);
      move_right <= right_any_n & (~left_any_n  |  last_dir_n);

      fire <= 1'b0;
      if (mk_space && !space_h && cool_cnt == '0) begin
        fire     <= 1'b1;
        cool_cnt <= COOL_W'(FIRE_COOLDOWN - 1);
      end else if (cool_cnt != '0) begin
        cool_cnt <= cool_cnt - 1'b1;
      end

      if (mk_esc)
        pause <= 1'b0;
      else if (mk_p && !p_h)
        pause <= ~pause;

      if (mapped_make)
        last_code <= ps2_key_data;
    end
  end

`ifdef WASD_KEYS_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_h <= 1'b0;
      d_h <= 1'b0;
    end else begin
      a_h <= alias_l_n;
      d_h <= alias_r_n;
    end
  end
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: vector table, directed multi-cycle sequences, then random bytes against a key-event model.
module tb_ps2_key_decoder;

  localparam int FC = 100;
  localparam int PT = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_key_pressed = 1'b0;
  logic [7:0] ps2_key_data = 8'h00;
  logic       move_left, move_right, fire, pause;
  logic [7:0] last_code;
  logic [1:0] prefix_state;

  ps2_key_decoder #(.FIRE_COOLDOWN(FC), .PREFIX_TIMEOUT(PT)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .move_left       (move_left),
    .move_right      (move_right),
    .fire            (fire),
    .pause           (pause),
    .last_code       (last_code),
    .prefix_state    (prefix_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fire_cnt = 0;

  always @(posedge clock) cyc++;
  always @(negedge clock) if (fire === 1'b1) fire_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ps2_key_pressed = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(1);
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    ps2_key_data = b;
    ps2_key_pressed = 1'b1;
    tick(1);
    ps2_key_pressed = 1'b0;
    tick(gap);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  function automatic logic [11:0] outs();
    return {move_left, move_right, fire, pause, last_code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  data;
    logic [11:0] exp;  // {move_left, move_right, fire, pause, last_code}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] d, input logic [3:0] flags, input logic [7:0] lc);
    vec_t v;
    v.data = d;
    v.exp  = {flags, lc};
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  pend[$];
  logic [11:0] exp_q[$];
  int          nostrobe, mcyc, last_fire;
  bit          have_fired, dir_right, m_pause;
  bit          h_left, h_right, h_a, h_d, h_space, h_p;
  logic [7:0]  m_last;

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    nostrobe = 0; mcyc = 0; last_fire = 0; have_fired = 0;
    dir_right = 0; m_pause = 0; m_last = 8'h00;
    h_left = 0; h_right = 0; h_a = 0; h_d = 0; h_space = 0; h_p = 0;
  endtask

  task automatic model_step(input bit s, input logic [7:0] b);
    bit m_fire, is_make, is_brk, ext, has_e0, has_f0, lft, rgt;
    m_fire = 0; is_make = 0; is_brk = 0; ext = 0; has_e0 = 0; has_f0 = 0;
    if (!s) begin
      nostrobe++;
      if (nostrobe >= PT) pend.delete();
    end else begin
      nostrobe = 0;
      foreach (pend[i]) begin
        if (pend[i] == 8'hE0) has_e0 = 1;
        if (pend[i] == 8'hF0) has_f0 = 1;
      end
      if (has_f0) begin
        is_brk = 1; ext = has_e0; pend.delete();
      end else if (b == 8'hF0) begin
        pend.push_back(b);
      end else if (pend.size() == 0 && b == 8'hE0) begin
        pend.push_back(b);
      end else if (pend.size() == 0 && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hE1})) begin
        is_make = 0;
      end else begin
        is_make = 1; ext = has_e0; pend.delete();
      end

      if (ext && b == 8'h6B && (is_make || is_brk)) begin
        h_left = is_make;
        if (is_make) begin dir_right = 0; m_last = b; end
      end
      if (ext && b == 8'h74 && (is_make || is_brk)) begin
        h_right = is_make;
        if (is_make) begin dir_right = 1; m_last = b; end
      end
`ifdef WASD_KEYS_EN
      if (!ext && b == 8'h1C && (is_make || is_brk)) begin
        h_a = is_make;
        if (is_make) begin dir_right = 0; m_last = b; end
      end
      if (!ext && b == 8'h23 && (is_make || is_brk)) begin
        h_d = is_make;
        if (is_make) begin dir_right = 1; m_last = b; end
      end
`endif
      if (!ext && b == 8'h29) begin
        if (is_make) begin
          if (!h_space && (!have_fired || (mcyc - last_fire) >= FC)) begin
            m_fire = 1; have_fired = 1; last_fire = mcyc;
          end
          h_space = 1; m_last = b;
        end else if (is_brk) h_space = 0;
      end
      if (!ext && b == 8'h4D) begin
        if (is_make) begin
          if (!h_p) m_pause = !m_pause;
          h_p = 1; m_last = b;
        end else if (is_brk) h_p = 0;
      end
      if (!ext && b == 8'h76 && is_make) begin
        m_pause = 0; m_last = b;
      end
    end
    mcyc++;
    lft = h_left | h_a;
    rgt = h_right | h_d;
    exp_q.push_back({lft && (!rgt || !dir_right), rgt && (!lft || dir_right), m_fire, m_pause, m_last});
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] pool[12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h29, 8'h4D,
                           8'h76, 8'hFA, 8'h1C, 8'h23, 8'h11, 8'hF0};

  initial begin
    int t0, base, idle_left;
    bit s;
    logic [7:0] b;
    logic [11:0] e;

    tick(1);
    check("reset_outputs", outs(), 12'h000);
    resetn = 1'b1;
    tick(1);

    // Table of single bytes with the outputs expected one cycle later.
    add(8'hE0, 4'b0000, 8'h00);
    add(8'h6B, 4'b1000, 8'h6B);
    add(8'hE0, 4'b1000, 8'h6B);
    add(8'h74, 4'b0100, 8'h74);
    add(8'hE0, 4'b0100, 8'h74);
    add(8'hF0, 4'b0100, 8'h74);
    add(8'h74, 4'b1000, 8'h74);
    add(8'hE0, 4'b1000, 8'h74);
    add(8'hF0, 4'b1000, 8'h74);
    add(8'h6B, 4'b0000, 8'h74);
    add(8'h29, 4'b0010, 8'h29);
    add(8'hF0, 4'b0000, 8'h29);
    add(8'h29, 4'b0000, 8'h29);
    add(8'h4D, 4'b0001, 8'h4D);
    add(8'h4D, 4'b0001, 8'h4D);
    add(8'hF0, 4'b0001, 8'h4D);
    add(8'h4D, 4'b0001, 8'h4D);
    add(8'h76, 4'b0000, 8'h76);
    add(8'hFA, 4'b0000, 8'h76);
    add(8'hE1, 4'b0000, 8'h76);
    foreach (tbl[i]) begin
      send_byte(tbl[i].data, 0);
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      tick(1);
      check($sformatf("vec%0d_fire_low", i), fire, 1'b0);
    end

    // Left press/hold/release timing.
    do_reset();
    send_byte(8'hE0, 0);
    check("left_before", move_left, 1'b0);
    send_byte(8'h6B, 0);
    check("left_rise", move_left, 1'b1);
    tick(10);
    check("left_held", move_left, 1'b1);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    check("left_before_break", move_left, 1'b1);
    send_byte(8'h6B, 0);
    check("left_fall", move_left, 1'b0);
    check("left_last_code", last_code, 8'h6B);

    // Fire cooldown: presses at +0, +50, +150.
    do_reset();
    t0 = cyc;
    base = fire_cnt;
    send_byte(8'h29, 0);
    check("fire_first", fire, 1'b1);
    send_byte(8'hF0, 0);
    send_byte(8'h29, 0);
    wait_until(t0 + 50);
    send_byte(8'h29, 0);
    check("fire_in_cooldown", fire, 1'b0);
    send_byte(8'hF0, 0);
    send_byte(8'h29, 0);
    wait_until(t0 + 150);
    send_byte(8'h29, 0);
    check("fire_after_cooldown", fire, 1'b1);
    tick(2);
    check("fire_pulse_count", fire_cnt - base, 2);
    send_byte(8'hF0, 0);
    send_byte(8'h29, 110);
    base = fire_cnt;
    send_byte(8'h29, 0);
    send_byte(8'h29, 0);
    send_byte(8'h29, 2);
    check("fire_typematic_count", fire_cnt - base, 1);

    // Pause toggling with repeats and Esc.
    do_reset();
    send_byte(8'h4D, 0);
    check("pause_on", pause, 1'b1);
    send_byte(8'h4D, 0);
    check("pause_repeat", pause, 1'b1);
    send_byte(8'hF0, 0);
    send_byte(8'h4D, 0);
    send_byte(8'h4D, 0);
    check("pause_off", pause, 1'b0);
    send_byte(8'hF0, 0);
    send_byte(8'h4D, 0);
    send_byte(8'h76, 0);
    check("pause_esc", pause, 1'b0);

    // Prefix timeout on either side of the limit.
    do_reset();
    send_byte(8'hE0, 25);
    send_byte(8'h6B, 0);
    check("timeout_expired_left", move_left, 1'b0);
    check("timeout_expired_code", last_code, 8'h00);
    tick(1);
    send_byte(8'hE0, 15);
    send_byte(8'h6B, 0);
    check("timeout_pending_left", move_left, 1'b1);

    // Reset in the middle of a break sequence.
    do_reset();
    send_byte(8'hE0, 0);
    send_byte(8'h74, 0);
    check("rst_right_held", move_right, 1'b1);
    send_byte(8'hE0, 0);
    send_byte(8'hF0, 0);
    resetn = 1'b0;
    #2;
    check("rst_async_outputs", outs(), 12'h000);
    tick(2);
    resetn = 1'b1;
    tick(1);
    send_byte(8'h74, 0);
    check("rst_partial_dropped", outs(), 12'h000);

    // Random byte stream against the model.
    do_reset();
    model_reset();
    idle_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (idle_left > 0) begin
        s = 0; b = 8'h00; idle_left--;
      end else begin
        s = 1;
        b = pool[$urandom_range(0, 11)];
        idle_left = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 25) : $urandom_range(0, 2);
      end
      ps2_key_pressed = s;
      ps2_key_data = b;
      model_step(s, b);
      tick(1);
      if (exp_q.size() == 0) begin
        check("rand_queue_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rand%0d", i), outs(), e);
      end
    end
    ps2_key_pressed = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the raw PS/2 set-2 scan-code byte stream from the keyboard interface into the game control signals `move_left`, `move_right`, `fire` and `pause`. It consumes `ps2_key_data`/`ps2_key_pressed` and drives the processor and VGA controller.
- Tracks make/break (`F0`) and extended (`E0`) prefixes.
- Holds direction levels, rate-limits fire pulses and debounces the pause toggle against typematic repeat.

## Interface
- `FIRE_COOLDOWN`, default 5_000_000: minimum cycles between two `fire` pulses (0.1 s at 50 MHz); must be ≥ 1.
- `PREFIX_TIMEOUT`, default 50_000: cycles a pending prefix waits for its next byte before being discarded.
- `clock`  in  1  system clock, all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `ps2_key_pressed`  in  1  one-cycle strobe: `ps2_key_data` holds a new byte.
- `ps2_key_data`  in  8  received scan-code byte.
- `move_left`  out  1  level: left is the active direction.
- `move_right`  out  1  level: right is the active direction.
- `fire`  out  1  one-cycle pulse per accepted space press.
- `pause`  out  1  level, toggled by each fresh P press.
- `last_code`  out  8  last complete make code accepted (debug).

## Operation
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK. Every transition below happens only on a cycle with `ps2_key_pressed` high.
  - IDLE: `E0` → EXT; `F0` → BRK; any other byte is a base make and stays in IDLE.
  - EXT: `F0` → EXT_BRK; any other byte is an extended make → IDLE.
  - BRK: any byte is a base break → IDLE.
  - EXT_BRK: any byte is an extended break → IDLE.
- Bytes `FA`, `AA`, `EE`, `FE`, `E1` received in IDLE are ignored and leave state unchanged.
- Key map:
  - left = extended `6B`; right = extended `74`.
  - fire = base `29` (space); pause = base `4D` (P); clear-pause = base `76` (Esc).
- Held flags `left_h`, `right_h`, `space_h`, `p_h`: set on make, cleared on break.
- Direction:
  - Register `last_dir` is set to L or R on each make of left or right.
  - `move_left = left_h & (~right_h | last_dir==L)`; `move_right` is the mirror.
  - So when both keys are held, the most recent make wins. Releasing one key leaves the other active.
- Fire:
  - A space make with `space_h`=0 and `cool_cnt`=0 pulses `fire` and loads `cool_cnt` with `FIRE_COOLDOWN-1`.
  - `cool_cnt` decrements to 0 and saturates there.
  - Typematic repeats (make while `space_h`=1) never fire.
  - A press during cooldown is dropped, not queued.
- Pause:
  - A P make with `p_h`=0 toggles `pause`; repeats are ignored.
  - Esc make forces `pause`=0.
- `last_code` is loaded with the final byte of every make of a mapped key. It is not loaded on breaks.
- Prefix timeout:
  - In EXT, BRK or EXT_BRK, a counter counts cycles without a strobe.
  - Reaching `PREFIX_TIMEOUT` returns the FSM to IDLE with no flag change.
  - The counter clears on every strobe.

## Timing
- All outputs are registered. Any output change appears 1 cycle after the strobe carrying the final byte of a code.
- `fire` is high for exactly 1 cycle.
- Reset values: `move_left`=0, `move_right`=0, `fire`=0, `pause`=0, `last_code`=8'h00. FSM=IDLE, all held flags 0, `cool_cnt`=0, timeout counter 0, `last_dir`=L.
- Reset asserted mid-sequence, e.g. between `E0` and `6B`: the partial code is discarded. The next byte after release is decoded from IDLE.
- Strobes on consecutive cycles are all processed; there is no back-pressure.
- Timeout and strobe on the same cycle: the strobe wins.
- Counter widths are set by `$clog2` of the respective parameter; no wrap is possible.

## Configuration
- `WASD_KEYS_EN`: when defined, base `1C` (A) aliases left and base `23` (D) aliases right.
  - The aliases OR into `left_h`/`right_h` through separate held flags and update `last_dir` the same way.
- Without the macro, `1C` and `23` are unmapped and ignored.

## Test plan
- `E0 6B`, wait 10 cycles, `E0 F0 6B` → `move_left` rises 1 cycle after `6B` and falls 1 cycle after the final `6B`; `last_code`=8'h6B.
- Left make, then right make, then right break → `move_right`=1/`move_left`=0 after the right make; `move_left`=1 again after the right break.
- `FIRE_COOLDOWN`=100: `29`, `F0 29`, then `29` at cycle +50 and `29` at cycle +150 → pulses at the first and third presses only. Also `29 29 29` without break → one pulse.
- `4D 4D F0 4D 4D F0 4D` → `pause` goes 1 then 0 (two toggles); a following `76` keeps it 0.
- `PREFIX_TIMEOUT`=20: `E0`, idle 25 cycles, then `6B` → `6B` is decoded as a base make, `move_left` stays 0. Same test with idle 15 → `move_left`=1.
- Assert `resetn`=0 after `E0 F0` while right is held → all outputs 0. Then `74` alone after reset → `move_right` stays 0.
